// File: rtl/led_pkg.sv
// Shared LED-mode definitions: button FSM states, blink period width and the
// mode-to-half-period table used by both the button controller and the blinker.
package led_pkg;

  localparam int PERIOD_W = 25;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } btn_state_e;

  // Each mode halves the toggle interval of the previous one (1 Hz .. 8 Hz at 50 MHz).
  function automatic logic [PERIOD_W-1:0] mode_half_period(input logic [1:0] mode_i);
    logic [PERIOD_W-1:0] hp_s;
    case (mode_i)
      2'd0:    hp_s = 25'd25_000_000;
      2'd1:    hp_s = 25'd12_500_000;
      2'd2:    hp_s = 25'd6_250_000;
      2'd3:    hp_s = 25'd3_125_000;
      default: hp_s = 25'd25_000_000;
    endcase
    return hp_s;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous level input; both flops reset to
// RESET_VAL so the output is quiet while reset is held.
module btn_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Metastability-settling shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/btn_mode_ctrl.sv
// Debounced push-button controller: short presses step the blink mode 0..3,
// a long press toggles the blinker enable once per press.
module btn_mode_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_n,
  output logic [1:0]          mode,
  output logic [PERIOD_W-1:0] half_period,
  output logic                blink_en,
  output logic                press_pulse,
  output logic                long_pulse
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic                sync_s;
  logic                btn_s;
  btn_state_e          state_q, state_d;
  logic [DW-1:0]       deb_q, deb_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                long_flag_q, long_flag_d;
  logic [1:0]          mode_q, mode_d;
  logic [PERIOD_W-1:0] half_period_q, half_period_d;
  logic                blink_en_q, blink_en_d;
  logic                press_pulse_q, press_pulse_d;
  logic                long_pulse_q, long_pulse_d;

  btn_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_n),
    .q_o (sync_s)
  );

  assign btn_s = ~sync_s;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      deb_q         <= '0;
      hold_q        <= '0;
      long_flag_q   <= 1'b0;
      mode_q        <= 2'd0;
      half_period_q <= 25'd25_000_000;
      blink_en_q    <= 1'b1;
      press_pulse_q <= 1'b0;
      long_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      deb_q         <= deb_d;
      hold_q        <= hold_d;
      long_flag_q   <= long_flag_d;
      mode_q        <= mode_d;
      half_period_q <= half_period_d;
      blink_en_q    <= blink_en_d;
      press_pulse_q <= press_pulse_d;
      long_pulse_q  <= long_pulse_d;
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_d       = state_q;
    deb_d         = deb_q;
    hold_d        = hold_q;
    long_flag_d   = long_flag_q;
    mode_d        = mode_q;
    blink_en_d    = blink_en_q;
    press_pulse_d = 1'b0;
    long_pulse_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_DEB_PRESS;
          deb_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DEB_PRESS: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d     = ST_HELD;
          hold_d      = '0;
          long_flag_d = 1'b0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end

      ST_HELD: begin
        // long_flag keeps the long press one-shot even if release bounces back here
        if (hold_q == HOLD_LAST) begin
          if (!long_flag_q) begin
            long_pulse_d = 1'b1;
            blink_en_d   = ~blink_en_q;
            long_flag_d  = 1'b1;
          end else begin
            long_pulse_d = 1'b0;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
        if (!btn_s) begin
          state_d = ST_DEB_RELEASE;
          deb_d   = '0;
        end else begin
          state_d = ST_HELD;
        end
      end

      ST_DEB_RELEASE: begin
        if (btn_s) begin
          state_d = ST_HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_IDLE;
          if (!long_flag_q) begin
            press_pulse_d = 1'b1;
            mode_d        = mode_q + 2'd1;
          end else begin
            press_pulse_d = 1'b0;
          end
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    half_period_d = mode_half_period(mode_d);
  end

  assign mode        = mode_q;
  assign half_period = half_period_q;
  assign blink_en    = blink_en_q;
  assign press_pulse = press_pulse_q;
  assign long_pulse  = long_pulse_q;

endmodule

// File: doc/btn_mode_ctrl.md
BTN_MODE_CTRL -- requirements
Module: btn_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, 1_000_000, cycles the button must be stable (20 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, 50_000_000, hold cycles after press debounce that count as a long press (1 s).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic in this domain.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port btn_n, input, 1, raw board button, active-low, asynchronous to clk.
REQ-006 SHALL have port mode, output, 2, current blink mode 0..3.
REQ-007 SHALL have port half_period, output, 25, clk cycles per LED toggle, consumed directly by the LED blinker counter compare.
REQ-008 SHALL have port blink_en, output, 1, 1 = LED blinker runs, 0 = LED blinker holds.
REQ-009 SHALL have port press_pulse, output, 1, one-cycle strobe on an accepted short press.
REQ-010 SHALL have port long_pulse, output, 1, one-cycle strobe on an accepted long press.

Function
REQ-011 SHALL pass btn_n through a 2-flop synchronizer and invert it to btn_s (1 = pressed); raw btn_n SHALL not reach any other logic.
REQ-012 SHALL implement FSM states IDLE, DEB_PRESS, HELD, DEB_RELEASE with one shared debounce counter and one hold counter.
REQ-013 IDLE: btn_s=1 -> DEB_PRESS, debounce counter cleared.
REQ-014 DEB_PRESS: btn_s=0 -> IDLE, nothing emitted; debounce counter = DEBOUNCE_CYCLES-1 with btn_s=1 -> HELD, hold counter and long_flag cleared.
REQ-015 HELD: hold counter increments, saturating at LONG_PRESS_CYCLES-1; on the cycle it first equals LONG_PRESS_CYCLES-1 with long_flag=0, SHALL pulse long_pulse, toggle blink_en and set long_flag; btn_s=0 -> DEB_RELEASE, debounce counter cleared.
REQ-016 DEB_RELEASE: btn_s=1 -> HELD, hold counter and long_flag kept, debounce counter cleared; debounce counter = DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE.
REQ-017 On DEB_RELEASE -> IDLE with long_flag=0, SHALL pulse press_pulse and increment mode modulo 4 (3 wraps to 0); with long_flag=1, SHALL emit nothing and leave mode unchanged.
REQ-018 press_pulse, long_pulse, mode, blink_en SHALL be registered, updating on the transition edge and visible in the following cycle; each pulse SHALL be high for exactly one cycle.
REQ-019 half_period SHALL be a registered lookup of mode: 0 -> 25_000_000, 1 -> 12_500_000, 2 -> 6_250_000, 3 -> 3_125_000, updating on the same edge as mode.
REQ-020 Long press SHALL fire at most once per press, including across release bounces.
REQ-021 Counters SHALL be sized by $clog2 of their parameter and never wrap.

Reset
REQ-022 rst=1 SHALL asynchronously force: state IDLE, both synchronizer flops 1 (released), counters 0, long_flag 0, mode 0, half_period 25_000_000, blink_en 1, press_pulse 0, long_pulse 0.
REQ-023 Reset asserted mid-press SHALL discard the press; after release of reset with the button still held, the FSM SHALL treat it as a new press from IDLE.

Structure
REQ-024 Package led_pkg SHALL hold the FSM state enum, the 25-bit period width constant and the mode-to-half_period table, shared with the LED blinker.
REQ-025 The synchronizer SHALL be a separate sub-module btn_sync (2 flops, reset value parameter).

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-026 Reset then idle 50 cycles -> mode=0, half_period=25_000_000, blink_en=1, no pulses.
REQ-027 btn_n low 10 cycles then high 10 cycles -> exactly one press_pulse, mode 0->1, half_period=12_500_000.
REQ-028 Four clean short presses -> mode 1,2,3,0; half_period returns to 25_000_000 after the fourth.
REQ-029 btn_n low for 2 cycles only (bounce) -> no pulse, mode unchanged, FSM back in IDLE.
REQ-030 btn_n low 40 cycles, one 2-cycle high glitch at cycle 30, then release -> one long_pulse, blink_en 1->0, no press_pulse, mode unchanged.
REQ-031 rst asserted while HELD with btn_n still low, then deasserted -> outputs at reset values immediately, and a fresh press is accepted after debounce.
